// File: rtl/riscv_base_trace_capture_pkg.sv
// Shared layout of a captured trace entry.
// The stamp field sits at the top of the entry so every other field has a
// fixed bit offset whatever the stamp width is.
package riscv_base_trace_capture_pkg;

    localparam int TRACE_PC_LSB    = 0;
    localparam int TRACE_PC_MSB    = 31;
    localparam int TRACE_OP_LSB    = 32;
    localparam int TRACE_OP_MSB    = 63;
    localparam int TRACE_EXC_BIT   = 64;
    localparam int TRACE_GAP_BIT   = 65;
    localparam int TRACE_STAMP_LSB = 66;

    // Total entry width for a given stamp width: pc + opcode + exc + gap + stamp.
    function automatic int trace_entry_w(input int stamp_w);
        return TRACE_STAMP_LSB + stamp_w;
    endfunction

endpackage

// File: rtl/riscv_base_trace_fifo_mem.sv
// Storage array for the trace FIFO: one write port, one combinational read
// port addressed by the read pointer so the head is visible without latency.
module riscv_base_trace_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 98
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the entry presented by the controller; contents need no reset
    // because the controller masks the head while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/riscv_base_trace_capture.sv
// Commit-stream trace capture: buffers retired instructions in a
// first-word-fall-through FIFO, tagging each with a cycle stamp and a flag
// marking that entries were lost just before it.
module riscv_base_trace_capture
    import riscv_base_trace_capture_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int STAMP_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               flush_i,
    input  logic               commit_valid_i,
    input  logic [31:0]        commit_pc_i,
    input  logic [31:0]        commit_opcode_i,
    input  logic               commit_exc_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [31:0]        pc_o,
    output logic [31:0]        opcode_o,
    output logic               exc_o,
    output logic               gap_o,
    output logic [STAMP_W-1:0] stamp_o,
    output logic [ADDR_W:0]    level_o,
    output logic               full_o,
    output logic [STAMP_W-1:0] retire_count_o,
    output logic [STAMP_W-1:0] drop_count_o
);

    localparam int              LP_ENTRY_W = trace_entry_w(STAMP_W);
    localparam logic [ADDR_W:0] LP_DEPTH   = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]     r_wptr;
    logic [ADDR_W-1:0]     r_rptr;
    logic [ADDR_W:0]       r_level;
    logic                  r_gap_pending;
    logic [STAMP_W-1:0]    r_cycle;
    logic [STAMP_W-1:0]    r_retire;
    logic [STAMP_W-1:0]    r_drop;

    logic                  w_commit;
    logic                  w_valid;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_write;
    logic                  w_drop;
    logic [LP_ENTRY_W-1:0] w_wdata;
    logic [LP_ENTRY_W-1:0] w_rdata;

    assign w_commit = commit_valid_i & enable_i;
    assign w_valid  = (r_level != '0);
    assign w_full   = (r_level == LP_DEPTH);
    assign w_push   = w_commit & ~flush_i;
    assign w_pop    = w_valid & ready_i & ~flush_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_write  = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    assign w_wdata  = {r_cycle, r_gap_pending, commit_exc_i, commit_opcode_i, commit_pc_i};

    riscv_base_trace_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (LP_ENTRY_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_write),
        .waddr_i (r_wptr),
        .wdata_i (w_wdata),
        .raddr_i (r_rptr),
        .rdata_o (w_rdata)
    );

    // Free-running cycle stamp; flush deliberately leaves it alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + STAMP_W'(1);
        end
    end

    // Retire count sees every enabled commit (even flushed or dropped ones);
    // drop count saturates so a long overflow never looks like a small one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retire <= '0;
            r_drop   <= '0;
        end else begin
            if (w_commit) begin
                r_retire <= r_retire + STAMP_W'(1);
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + STAMP_W'(1);
            end
        end
    end

    // Pointer, occupancy and gap tracking; flush overrides push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_gap_pending <= 1'b0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            // Discarded contents or a commit swallowed by the flush both
            // leave a hole the consumer must be told about.
            if (w_valid || w_commit) begin
                r_gap_pending <= 1'b1;
            end
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            if (w_write && !w_pop) begin
                r_level <= r_level + (ADDR_W+1)'(1);
            end else if (!w_write && w_pop) begin
                r_level <= r_level - (ADDR_W+1)'(1);
            end
            if (w_drop) begin
                r_gap_pending <= 1'b1;
            end else if (w_write) begin
                r_gap_pending <= 1'b0;
            end
        end
    end

    // Head fields are forced to zero while empty so stale array data never shows.
    assign valid_o        = w_valid;
    assign pc_o           = w_valid ? w_rdata[TRACE_PC_MSB:TRACE_PC_LSB] : '0;
    assign opcode_o       = w_valid ? w_rdata[TRACE_OP_MSB:TRACE_OP_LSB] : '0;
    assign exc_o          = w_valid & w_rdata[TRACE_EXC_BIT];
    assign gap_o          = w_valid & w_rdata[TRACE_GAP_BIT];
    assign stamp_o        = w_valid ? w_rdata[TRACE_STAMP_LSB +: STAMP_W] : '0;
    assign level_o        = r_level;
    assign full_o         = w_full;
    assign retire_count_o = r_retire;
    assign drop_count_o   = r_drop;

endmodule

// File: tb/tb_riscv_base_trace_capture.sv
// Bench for riscv_base_trace_capture: queue-based reference model checked
// every cycle, plus directed literal expectations for each scenario.
module tb_riscv_base_trace_capture;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int STAMP_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b1;
    logic        flush = 1'b0;
    logic        cv = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] op = '0;
    logic        exc = 1'b0;
    logic        ready = 1'b0;

    logic               valid_o;
    logic [31:0]        pc_o;
    logic [31:0]        opcode_o;
    logic               exc_o;
    logic               gap_o;
    logic [STAMP_W-1:0] stamp_o;
    logic [ADDR_W:0]    level_o;
    logic               full_o;
    logic [STAMP_W-1:0] retire_o;
    logic [STAMP_W-1:0] drop_o;

    riscv_base_trace_capture #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .STAMP_W (STAMP_W)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .enable_i        (enable),
        .flush_i         (flush),
        .commit_valid_i  (cv),
        .commit_pc_i     (pc),
        .commit_opcode_i (op),
        .commit_exc_i    (exc),
        .valid_o         (valid_o),
        .ready_i         (ready),
        .pc_o            (pc_o),
        .opcode_o        (opcode_o),
        .exc_o           (exc_o),
        .gap_o           (gap_o),
        .stamp_o         (stamp_o),
        .level_o         (level_o),
        .full_o          (full_o),
        .retire_count_o  (retire_o),
        .drop_count_o    (drop_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] op;
        logic        exc;
        logic        gap;
        logic [31:0] stamp;
    } ent_t;

    ent_t        mq[$];
    bit          m_gap = 1'b0;
    int unsigned m_cycle = 0;
    int unsigned m_retire = 0;
    int unsigned m_drop = 0;

    logic [31:0] log_pc[$];
    bit          log_gap[$];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of entries updated once per clock edge.
    initial begin
        forever begin
            bit   c;
            ent_t e;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_gap = 1'b0;
                m_cycle = 0;
                m_retire = 0;
                m_drop = 0;
            end else begin
                c = cv && enable;
                if (c) m_retire++;
                if (flush) begin
                    if (mq.size() != 0 || c) m_gap = 1'b1;
                    mq.delete();
                end else begin
                    if (mq.size() != 0 && ready) void'(mq.pop_front());
                    if (c) begin
                        if (mq.size() < DEPTH) begin
                            e.pc = pc;
                            e.op = op;
                            e.exc = exc;
                            e.gap = m_gap;
                            e.stamp = m_cycle;
                            mq.push_back(e);
                            m_gap = 1'b0;
                        end else begin
                            if (m_drop != 32'hFFFF_FFFF) m_drop++;
                            m_gap = 1'b1;
                        end
                    end
                end
                m_cycle++;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of accepted heads.
    initial begin
        forever begin
            bit mv;
            @(negedge clk);
            if (chk_en) begin
                mv = (mq.size() != 0);
                chk("valid", valid_o, mv);
                chk("level", level_o, mq.size());
                chk("full", full_o, mq.size() == DEPTH);
                chk("retire", retire_o, m_retire);
                chk("drop", drop_o, m_drop);
                if (mv) begin
                    chk("pc", pc_o, mq[0].pc);
                    chk("opcode", opcode_o, mq[0].op);
                    chk("exc", exc_o, mq[0].exc);
                    chk("gap", gap_o, mq[0].gap);
                    chk("stamp", stamp_o, mq[0].stamp);
                end else begin
                    chk("pc_empty", pc_o, 0);
                    chk("opcode_empty", opcode_o, 0);
                    chk("exc_empty", exc_o, 0);
                    chk("gap_empty", gap_o, 0);
                    chk("stamp_empty", stamp_o, 0);
                end
                if (valid_o && ready && !flush) begin
                    log_pc.push_back(pc_o);
                    log_gap.push_back(gap_o);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        chk_en = 1'b1;
        do_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_full", full_o, 0);

        // Single commit stamped at cycle 3, popped the following cycle.
        ready = 1'b1;
        repeat (3) step();
        cv = 1'b1; pc = 32'h8000_0000; op = 32'h0050_0093;
        step();
        cv = 1'b0;
        chk("t1_valid", valid_o, 1);
        chk("t1_pc", pc_o, 32'h8000_0000);
        chk("t1_op", opcode_o, 32'h0050_0093);
        chk("t1_stamp", stamp_o, 3);
        chk("t1_gap", gap_o, 0);
        step();
        chk("t1_level", level_o, 0);

        // Overflow: 20 commits into a stalled FIFO, then drain.
        do_reset();
        ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cv = 1'b1; pc = 32'h100 + 4 * n; op = n; exc = n[0];
            step();
        end
        cv = 1'b0; exc = 1'b0;
        chk("t2_level", level_o, 16);
        chk("t2_full", full_o, 1);
        chk("t2_drop", drop_o, 4);
        chk("t2_retire", retire_o, 20);
        ready = 1'b1;
        log_pc.delete(); log_gap.delete();
        step();
        cv = 1'b1; pc = 32'h200; op = 32'h13;
        step();
        cv = 1'b0;
        repeat (20) step();
        chk("t2_count", log_pc.size(), 17);
        if (log_pc.size() == 17) begin
            for (int n = 0; n < 16; n++) begin
                chk("t2_order_pc", log_pc[n], 32'h100 + 4 * n);
                chk("t2_order_gap", log_gap[n], 0);
            end
            chk("t2_last_pc", log_pc[16], 32'h200);
            chk("t2_last_gap", log_gap[16], 1);
        end

        // Full FIFO with simultaneous pop and push: no drop.
        ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cv = 1'b1; pc = 32'h300 + 4 * n; op = 32'h1000 + n;
            step();
        end
        chk("t3_full", full_o, 1);
        ready = 1'b1; cv = 1'b1; pc = 32'h400; op = 32'h2000;
        log_pc.delete(); log_gap.delete();
        step();
        cv = 1'b0;
        chk("t3_level", level_o, 16);
        chk("t3_drop", drop_o, 4);
        repeat (20) step();
        chk("t3_count", log_pc.size(), 17);
        if (log_pc.size() == 17) begin
            for (int n = 0; n < 16; n++) begin
                chk("t3_order_pc", log_pc[n], 32'h300 + 4 * n);
            end
            chk("t3_last_pc", log_pc[16], 32'h400);
            chk("t3_last_gap", log_gap[16], 0);
        end

        // Flush with a simultaneous commit.
        ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cv = 1'b1; pc = 32'h500 + 4 * n; op = 32'h3000 + n;
            step();
        end
        cv = 1'b1; flush = 1'b1; pc = 32'h5FC;
        step();
        cv = 1'b0; flush = 1'b0;
        chk("t4_valid", valid_o, 0);
        chk("t4_level", level_o, 0);
        chk("t4_retire", retire_o, 44);
        cv = 1'b1; pc = 32'h600; op = 32'h4000;
        step();
        cv = 1'b0;
        chk("t4_head_pc", pc_o, 32'h600);
        chk("t4_head_gap", gap_o, 1);
        ready = 1'b1;
        step();

        // Capture disabled: commits are ignored entirely.
        enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cv = 1'b1; pc = 32'h700 + 4 * n;
            step();
            chk("t5_valid", valid_o, 0);
        end
        cv = 1'b0; enable = 1'b1;
        chk("t5_level", level_o, 0);
        chk("t5_retire", retire_o, 45);

        // Asynchronous reset mid-stream.
        ready = 1'b0;
        for (int n = 0; n < 7; n++) begin
            cv = 1'b1; pc = 32'h900 + 4 * n; op = 32'h5000 + n;
            step();
        end
        cv = 1'b0;
        chk("t6_level_pre", level_o, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", valid_o, 0);
        chk("t6_level", level_o, 0);
        chk("t6_full", full_o, 0);
        chk("t6_pc", pc_o, 0);
        chk("t6_op", opcode_o, 0);
        chk("t6_stamp", stamp_o, 0);
        chk("t6_retire", retire_o, 0);
        chk("t6_drop", drop_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        cv = 1'b1; pc = 32'h800; op = 32'h6000;
        step();
        cv = 1'b0;
        chk("t6_stamp_after", stamp_o, 2);
        chk("t6_pc_after", pc_o, 32'h800);
        chk("t6_gap_after", gap_o, 0);
        ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
